// File: rtl/jedro_1_defines.sv
// ============================================================================
// Module      : jedro_1_defines (package)
// Description : Branch funct3 encodings and branch-unit FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jedro_1_defines;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [0:0] {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_e;

endpackage : jedro_1_defines

`default_nettype wire

// File: rtl/jedro_1_branch_cmp.sv
// ============================================================================
// Module      : jedro_1_branch_cmp
// Description : Combinational RV32I branch comparator (taken / illegal).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jedro_1_branch_cmp
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  taken_o,
  output logic                  illegal_o
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (rs1_data_i == rs2_data_i);
  assign w_lt  = ($signed(rs1_data_i) < $signed(rs2_data_i));
  assign w_ltu = (rs1_data_i < rs2_data_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BR_EQ:   taken_o = w_eq;
      BR_NE:   taken_o = ~w_eq;
      BR_LT:   taken_o = w_lt;
      BR_GE:   taken_o = ~w_lt;
      BR_LTU:  taken_o = w_ltu;
      BR_GEU:  taken_o = ~w_ltu;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule : jedro_1_branch_cmp

`default_nettype wire

// File: rtl/jedro_1_branch_unit.sv
// ============================================================================
// Module      : jedro_1_branch_unit
// Description : Branch resolution unit with registered redirect and
//               multi-cycle flush. Optional statistics counters are enabled
//               by defining JEDRO_1_BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jedro_1_branch_unit
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] imm_i,
  output logic                  jmp_o,
  output logic [ADDR_WIDTH-1:0] jmp_addr_o,
  output logic                  flush_o,
  output logic                  misaligned_o,
  output logic                  illegal_o
`ifdef JEDRO_1_BRANCH_STATS_EN
  ,
  output logic [31:0]           taken_cnt_o,
  output logic [31:0]           total_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  br_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  jmp_q, jmp_d;
  logic                  mis_q, mis_d;
  logic                  ill_q, ill_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  w_taken;
  logic                  w_illegal;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_target;

  jedro_1_branch_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .taken_o    (w_taken),
    .illegal_o  (w_illegal)
  );

  // Modulo-2^ADDR_WIDTH add; overflow is intentionally dropped.
  assign w_target = pc_i + imm_i;
  assign ready_o  = (state_q == BR_IDLE);
  assign w_accept = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jmp_d   = 1'b0;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      BR_IDLE: begin
        if (w_accept) begin
          addr_d = w_target;
          if (w_illegal) begin
            ill_d = 1'b1;
          end else if (w_taken) begin
            if (w_target[1:0] == 2'b00) begin
              jmp_d   = 1'b1;
              state_d = BR_FLUSH;
              cnt_d   = FLUSH_LOAD;
            end else begin
              mis_d = 1'b1;
            end
          end
        end
      end
      BR_FLUSH: begin
        // Counter holds the flush cycles still to run including this one.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BR_IDLE;
      cnt_q   <= '0;
      jmp_q   <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jmp_q   <= jmp_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      addr_q  <= addr_d;
    end
  end

  assign jmp_o        = jmp_q;
  assign jmp_addr_o   = addr_q;
  assign flush_o      = (state_q == BR_FLUSH);
  assign misaligned_o = mis_q;
  assign illegal_o    = ill_q;

`ifdef JEDRO_1_BRANCH_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] total_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_q <= '0;
      total_cnt_q <= '0;
    end else if (w_accept && !w_illegal) begin
      total_cnt_q <= total_cnt_q + 32'd1;
      if (w_taken) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign taken_cnt_o = taken_cnt_q;
  assign total_cnt_o = total_cnt_q;
`endif

endmodule : jedro_1_branch_unit

`default_nettype wire

// File: tb/tb_jedro_1_branch_unit.sv
// ============================================================================
// Module      : tb_jedro_1_branch_unit
// Description : Directed self-checking bench for jedro_1_branch_unit.
//               Stats checks are compiled when JEDRO_1_BRANCH_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jedro_1_branch_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        flush;
  logic        mis;
  logic        ill;
`ifdef JEDRO_1_BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] total_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  jedro_1_branch_unit #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .ready_o      (ready),
    .funct3_i     (funct3),
    .rs1_data_i   (rs1),
    .rs2_data_i   (rs2),
    .pc_i         (pc),
    .imm_i        (imm),
    .jmp_o        (jmp),
    .jmp_addr_o   (jmp_addr),
    .flush_o      (flush),
    .misaligned_o (mis),
    .illegal_o    (ill)
`ifdef JEDRO_1_BRANCH_STATS_EN
    ,
    .taken_cnt_o  (taken_cnt),
    .total_cnt_o  (total_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
    valid  = v;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = i;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_jmp",   {31'd0, jmp},   32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mis",   {31'd0, mis},   32'd0);
    chk("rst_ill",   {31'd0, ill},   32'd0);
    chk("rst_addr",  jmp_addr,       32'd0);
`ifdef JEDRO_1_BRANCH_STATS_EN
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    chk("rst_total_cnt", total_cnt, 32'd0);
`endif

    // BNE equal operands: not taken, then an illegal op accepted the very next cycle.
    drive(1'b1, 3'b001, 32'd5, 32'd5, 32'h40, 32'h10);
    tick();
    chk("bne_nt_jmp",   {31'd0, jmp},   32'd0);
    chk("bne_nt_flush", {31'd0, flush}, 32'd0);
    chk("bne_nt_ready", {31'd0, ready}, 32'd1);
    drive(1'b1, 3'b010, 32'd1, 32'd2, 32'h40, 32'h10);
    tick();
    chk("ill_pulse", {31'd0, ill},   32'd1);
    chk("ill_jmp",   {31'd0, jmp},   32'd0);
    chk("ill_flush", {31'd0, flush}, 32'd0);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("ill_one_cycle", {31'd0, ill}, 32'd0);

    // BNE taken with negative immediate; an illegal op held during flush must wait.
    drive(1'b1, 3'b001, 32'd0, 32'd3, 32'h100, 32'hFFFF_FFF8);
    tick();
    chk("bne_t_jmp",    {31'd0, jmp},   32'd1);
    chk("bne_t_addr",   jmp_addr,       32'h0000_00F8);
    chk("bne_t_flush0", {31'd0, flush}, 32'd1);
    chk("bne_t_ready0", {31'd0, ready}, 32'd0);
    drive(1'b1, 3'b011, 32'd0, 32'd0, 32'h0, 32'h0);
    tick();
    chk("flush1_jmp",   {31'd0, jmp},   32'd0);
    chk("flush1_flush", {31'd0, flush}, 32'd1);
    chk("flush1_ready", {31'd0, ready}, 32'd0);
    chk("flush1_ill",   {31'd0, ill},   32'd0);
    tick();
    chk("flush_end_flush", {31'd0, flush}, 32'd0);
    chk("flush_end_ready", {31'd0, ready}, 32'd1);
    chk("flush_end_ill",   {31'd0, ill},   32'd0);
    tick();
    chk("held_op_ill", {31'd0, ill}, 32'd1);

    // BLT signed taken, BLTU not taken, BGEU taken on the same operands.
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
    tick();
    chk("blt_jmp",  {31'd0, jmp}, 32'd1);
    chk("blt_addr", jmp_addr,     32'h240);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk("blt_ready_back", {31'd0, ready}, 32'd1);
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
    tick();
    chk("bltu_jmp",   {31'd0, jmp},   32'd0);
    chk("bltu_flush", {31'd0, flush}, 32'd0);
    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h20);
    tick();
    chk("bgeu_jmp",  {31'd0, jmp}, 32'd1);
    chk("bgeu_addr", jmp_addr,     32'h320);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();

    // BEQ taken to a misaligned target.
    drive(1'b1, 3'b000, 32'd7, 32'd7, 32'h0, 32'h6);
    tick();
    chk("mis_pulse", {31'd0, mis},   32'd1);
    chk("mis_addr",  jmp_addr,       32'h6);
    chk("mis_jmp",   {31'd0, jmp},   32'd0);
    chk("mis_flush", {31'd0, flush}, 32'd0);
    chk("mis_ready", {31'd0, ready}, 32'd1);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("mis_one_cycle", {31'd0, mis}, 32'd0);

    // Reset in the middle of a flush.
    drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h400, 32'h8);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_jmp",   {31'd0, jmp},   32'd0);
    chk("midrst_addr",  jmp_addr,       32'd0);

    // An op presented together with reset is dropped.
    rst = 1'b1;
    drive(1'b1, 3'b010, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rst_drop_ill0", {31'd0, ill}, 32'd0);
    tick();
    chk("rst_drop_ill1", {31'd0, ill}, 32'd0);

`ifdef JEDRO_1_BRANCH_STATS_EN
    // Three taken, two not-taken, one illegal (not counted).
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h1000, 32'h10);
      tick();
      drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
      tick();
    end
    drive(1'b1, 3'b001, 32'd4, 32'd4, 32'h0, 32'h0);
    tick();
    drive(1'b1, 3'b101, 32'd1, 32'd2, 32'h0, 32'h0);
    tick();
    drive(1'b1, 3'b011, 32'd1, 32'd2, 32'h0, 32'h0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("stats_taken", taken_cnt, 32'd3);
    chk("stats_total", total_cnt, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats_rst_taken", taken_cnt, 32'd0);
    chk("stats_rst_total", total_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jedro_1_branch_unit

`default_nettype wire
